wm_phase_timer: RTL and testbench

- Parametrised phase timer for the washing-machine controller. It sits beside the controller FSM and watches its `state` code.
- For each timed phase it counts controller-defined ticks and raises the phase-complete flag the FSM waits on: fill, heat, wash, rinse and spin.
- Over the fixed single-rate timer it adds:
  - per-phase durations set by parameter
  - a clock prescaler
  - a pause input
  - automatic restart on every state change
  - a one-cycle `phase_Done` pulse

---
 rtl/wm_phase_timer.sv | 113 +++++++++++
 tb/tb_wm_phase_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - per-phase tick timer for the washing-machine controller
// Optional `remaining` output enabled by macro WM_TIMER_REMAINING_EN.
module wm_phase_timer #(
    parameter int STATE_W    = 3,
    parameter int CNT_W      = 8,
    parameter int PRESCALE   = 1,
    parameter int FILL_TIME  = 2,
    parameter int HEAT_TIME  = 3,
    parameter int WASH_TIME  = 5,
    parameter int RINSE_TIME = 3,
    parameter int SPIN_TIME  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic               pause,
    output logic               sig_Full,
    output logic               sig_Temperature,
    output logic               sig_Completed,
    output logic               phase_Done
`ifdef WM_TIMER_REMAINING_EN
    ,
    output logic [CNT_W-1:0]   remaining
`endif
);

    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [STATE_W-1:0] ST_FILL  = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_HEAT  = STATE_W'(3);
    localparam logic [STATE_W-1:0] ST_WASH  = STATE_W'(4);
    localparam logic [STATE_W-1:0] ST_RINSE = STATE_W'(5);
    localparam logic [STATE_W-1:0] ST_SPIN  = STATE_W'(6);

    logic [STATE_W-1:0] prev_state;
    logic [PW-1:0]      presc;
    logic [CNT_W-1:0]   elapsed;
    logic [CNT_W-1:0]   elapsed_inc;
    logic [CNT_W-1:0]   dur;
    logic               timed;
    logic               is_fill;
    logic               is_heat;
    logic               is_compl;
    logic               flag_cur;
    logic               tick;

    always_comb begin
        timed    = 1'b0;
        dur      = '0;
        is_fill  = 1'b0;
        is_heat  = 1'b0;
        is_compl = 1'b0;
        case (state)
            ST_FILL:  begin timed = 1'b1; dur = CNT_W'(FILL_TIME);  is_fill  = 1'b1; end
            ST_HEAT:  begin timed = 1'b1; dur = CNT_W'(HEAT_TIME);  is_heat  = 1'b1; end
            ST_WASH:  begin timed = 1'b1; dur = CNT_W'(WASH_TIME);  is_compl = 1'b1; end
            ST_RINSE: begin timed = 1'b1; dur = CNT_W'(RINSE_TIME); is_compl = 1'b1; end
            ST_SPIN:  begin timed = 1'b1; dur = CNT_W'(SPIN_TIME);  is_compl = 1'b1; end
            default:  ;
        endcase
        flag_cur    = (is_fill & sig_Full) | (is_heat & sig_Temperature) | (is_compl & sig_Completed);
        tick        = (presc == PRESC_LAST);
        elapsed_inc = elapsed + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_state      <= '0;
            presc           <= '0;
            elapsed         <= '0;
            sig_Full        <= 1'b0;
            sig_Temperature <= 1'b0;
            sig_Completed   <= 1'b0;
            phase_Done      <= 1'b0;
        end else begin
            phase_Done <= 1'b0;
            // A state change always restarts the phase, even if a tick expires on this edge.
            if (state != prev_state) begin
                prev_state      <= state;
                presc           <= '0;
                elapsed         <= '0;
                sig_Full        <= 1'b0;
                sig_Temperature <= 1'b0;
                sig_Completed   <= 1'b0;
            end else if (!timed) begin
                presc           <= '0;
                elapsed         <= '0;
                sig_Full        <= 1'b0;
                sig_Temperature <= 1'b0;
                sig_Completed   <= 1'b0;
            end else if (!flag_cur && !pause) begin
                if (tick) begin
                    presc   <= '0;
                    elapsed <= elapsed_inc;
                    if (elapsed_inc == dur) begin
                        sig_Full        <= is_fill;
                        sig_Temperature <= is_heat;
                        sig_Completed   <= is_compl;
                        phase_Done      <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

`ifdef WM_TIMER_REMAINING_EN
    assign remaining = (timed && !flag_cur) ? (dur - elapsed) : '0;
`endif

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - directed-vector bench for wm_phase_timer
module tb_wm_phase_timer;

    logic       clock;
    logic       reset;
    logic [2:0] state;
    logic       pause;
    logic       full_a, temp_a, compl_a, done_a;
    logic       full_b, temp_b, compl_b, done_b;
`ifdef WM_TIMER_REMAINING_EN
    logic [7:0] rem_a, rem_b;
`endif
    int n_cmp;
    int n_bad;

    wm_phase_timer dut_a (
        .clock(clock), .reset(reset), .state(state), .pause(pause),
        .sig_Full(full_a), .sig_Temperature(temp_a), .sig_Completed(compl_a), .phase_Done(done_a)
`ifdef WM_TIMER_REMAINING_EN
        , .remaining(rem_a)
`endif
    );

    wm_phase_timer #(.PRESCALE(4)) dut_b (
        .clock(clock), .reset(reset), .state(state), .pause(pause),
        .sig_Full(full_b), .sig_Temperature(temp_b), .sig_Completed(compl_b), .phase_Done(done_b)
`ifdef WM_TIMER_REMAINING_EN
        , .remaining(rem_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; state = 3'd0; pause = 1'b0;
        step(); step();
        n_cmp++; if ({full_a, temp_a, compl_a, done_a} !== 4'b0000) begin n_bad++; $display("FAIL reset_a: got %b want 0000", {full_a, temp_a, compl_a, done_a}); end
        n_cmp++; if ({full_b, temp_b, compl_b, done_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_b: got %b want 0000", {full_b, temp_b, compl_b, done_b}); end
        state = 3'd2; reset = 1'b0;
        step();  // E0
        for (int k = 1; k <= 1; k++) begin
            n_cmp++; if (full_a !== 1'b0) begin n_bad++; $display("FAIL fill_early_e%0d: got %b want 0", k - 1, full_a); end
            step();
        end
        n_cmp++; if (full_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL fill_e1: got full=%b done=%b want 0 0", full_a, done_a); end
        step();  // E2
        n_cmp++; if (full_a !== 1'b1 || done_a !== 1'b1) begin n_bad++; $display("FAIL fill_e2: got full=%b done=%b want 1 1", full_a, done_a); end
        step();
        n_cmp++; if (full_a !== 1'b1 || done_a !== 1'b0) begin n_bad++; $display("FAIL fill_e3: got full=%b done=%b want 1 0", full_a, done_a); end
        n_cmp++; if (temp_a !== 1'b0 || compl_a !== 1'b0) begin n_bad++; $display("FAIL fill_other_flags: got temp=%b compl=%b want 0 0", temp_a, compl_a); end
    endtask

    task automatic test_prescale();
        state = 3'd4;
        step();  // E0
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (compl_b !== 1'b0) begin n_bad++; $display("FAIL presc_early_e%0d: got %b want 0", k, compl_b); end
            if (k < 19) step();
        end
        step();  // E20
        n_cmp++; if (compl_b !== 1'b1 || done_b !== 1'b1) begin n_bad++; $display("FAIL presc_e20: got compl=%b done=%b want 1 1", compl_b, done_b); end
        for (int k = 21; k <= 30; k++) begin
            step();
            n_cmp++; if (compl_b !== 1'b1 || done_b !== 1'b0) begin n_bad++; $display("FAIL presc_hold_e%0d: got compl=%b done=%b want 1 0", k, compl_b, done_b); end
        end
        n_cmp++; if (full_b !== 1'b0 || temp_b !== 1'b0) begin n_bad++; $display("FAIL presc_other_flags: got full=%b temp=%b want 0 0", full_b, temp_b); end
    endtask

    task automatic test_pause();
        state = 3'd3;
        step(); step();  // E0, E1
        pause = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            n_cmp++; if (temp_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL pause_e%0d: got temp=%b done=%b want 0 0", k, temp_a, done_a); end
        end
        pause = 1'b0;
        step();  // E6
        n_cmp++; if (temp_a !== 1'b0) begin n_bad++; $display("FAIL pause_e6: got %b want 0", temp_a); end
        step();  // E7
        n_cmp++; if (temp_a !== 1'b1 || done_a !== 1'b1) begin n_bad++; $display("FAIL pause_e7: got temp=%b done=%b want 1 1", temp_a, done_a); end
    endtask

    task automatic test_collision();
        state = 3'd5;
        step(); step(); step();  // E0..E2, elapsed 2 of 3
        state = 3'd6;
        step();  // expiring edge, state change wins
        n_cmp++; if (compl_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL collide_edge: got compl=%b done=%b want 0 0", compl_a, done_a); end
        step(); step();
        n_cmp++; if (compl_a !== 1'b0) begin n_bad++; $display("FAIL spin_early: got %b want 0", compl_a); end
        step();
        n_cmp++; if (compl_a !== 1'b1 || done_a !== 1'b1) begin n_bad++; $display("FAIL spin_done: got compl=%b done=%b want 1 1", compl_a, done_a); end
    endtask

    task automatic test_reset_mid();
        step();
        reset = 1'b1;
        #1;
        n_cmp++; if ({full_a, temp_a, compl_a, done_a} !== 4'b0000) begin n_bad++; $display("FAIL async_reset_flag: got %b want 0000", {full_a, temp_a, compl_a, done_a}); end
        reset = 1'b0; state = 3'd4;
        step(); step(); step(); step();  // E0..E3, elapsed 3
        n_cmp++; if (compl_a !== 1'b0) begin n_bad++; $display("FAIL wash_mid: got %b want 0", compl_a); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({full_a, temp_a, compl_a, done_a} !== 4'b0000) begin n_bad++; $display("FAIL async_reset_mid: got %b want 0000", {full_a, temp_a, compl_a, done_a}); end
        step();
        reset = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            n_cmp++; if (compl_a !== 1'b0) begin n_bad++; $display("FAIL wash_restart_e%0d: got %b want 0", k, compl_a); end
        end
        step();
        n_cmp++; if (compl_a !== 1'b1 || done_a !== 1'b1) begin n_bad++; $display("FAIL wash_restart_e5: got compl=%b done=%b want 1 1", compl_a, done_a); end
    endtask

    task automatic test_untimed();
        state = 3'd7;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if ({full_a, temp_a, compl_a, done_a} !== 4'b0000) begin n_bad++; $display("FAIL untimed_%0d: got %b want 0000", k, {full_a, temp_a, compl_a, done_a}); end
        end
    endtask

`ifdef WM_TIMER_REMAINING_EN
    task automatic test_remaining();
        logic [7:0] exp_rem;
        state = 3'd1;
        step();
        n_cmp++; if (rem_a !== 8'd0) begin n_bad++; $display("FAIL rem_untimed: got %0d want 0", rem_a); end
        state = 3'd4;
        for (int k = 0; k <= 5; k++) begin
            step();
            exp_rem = 8'(5 - k);
            n_cmp++; if (rem_a !== exp_rem) begin n_bad++; $display("FAIL rem_e%0d: got %0d want %0d", k, rem_a, exp_rem); end
        end
        state = 3'd1;
        step();
        n_cmp++; if (rem_a !== 8'd0) begin n_bad++; $display("FAIL rem_back_untimed: got %0d want 0", rem_a); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_prescale();
        test_pause();
        test_collision();
        test_reset_mid();
        test_untimed();
`ifdef WM_TIMER_REMAINING_EN
        test_remaining();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
